// File: rtl/deserializer.sv
// Serial bus link receiver: synchronises sclk/sdata, shifts in one frame
// per start bit, checks stop bit and parity, and pulses a status output.
package bus_pkg;
  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef struct packed {
    logic        start;
    logic        cmd;
    logic [13:0] addr;
    logic [7:0]  data;
    logic        parity;
    logic        stop;
  } serial_frame_t;

  function automatic logic calc_parity(
    input logic        cmd,
    input logic [13:0] addr,
    input logic [7:0]  data
  );
    return ^{cmd, addr, data};
  endfunction
endpackage

module deserializer
  import bus_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          sclk_i,
  input  logic          sdata_i,
  output serial_frame_t frame_o,
  output logic          valid_o,
  output logic          parity_err_o,
  output logic          frame_err_o,
  output logic          busy_o
);

  localparam int FRAME_W = $bits(serial_frame_t);
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   sclk_prev;
  logic                   sclk_s;
  logic                   sdata_s;
  logic                   rise;

  logic [1:0]       state;
  serial_frame_t    shreg;
  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;
  logic             stop_bad;
  logic             par_bad;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_prev;
  assign busy_o  = (state != IDLE);

  assign stop_bad = ~shreg.stop;
  assign par_bad  = shreg.parity !=
                    calc_parity(shreg.cmd, shreg.addr, shreg.data);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync  <= '0;
      sdata_sync <= '0;
      sclk_prev  <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata_i};
      sclk_prev  <= sclk_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      tmo          <= '0;
      frame_o      <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          tmo <= '0;
          if (rise && sdata_s) begin
            shreg <= serial_frame_t'(FRAME_W'(1));
            cnt   <= CNT_W'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise) begin
            shreg <= {shreg[FRAME_W-2:0], sdata_s};
            cnt   <= cnt + 1'b1;
            tmo   <= '0;
            if (cnt == CNT_LAST) state <= CHECK;
          end else begin
            if (tmo != TMO_MAX) tmo <= tmo + 1'b1;
            if (tmo >= TMO_LAST) state <= ABORT;
          end
        end
        CHECK: begin
          frame_o <= shreg;
          unique case (1'b1)
            stop_bad:             frame_err_o  <= 1'b1;
            !stop_bad && par_bad:  parity_err_o <= 1'b1;
            !stop_bad && !par_bad: valid_o      <= 1'b1;
          endcase
          shreg <= '0;
          cnt   <= '0;
          state <= IDLE;
        end
        ABORT: begin
          frame_err_o <= 1'b1;
          shreg       <= '0;
          cnt         <= '0;
          tmo         <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Bench for the serial link receiver: bit-bangs frames on sclk/sdata and
// checks every status pulse and frame against a field-level model.
module tb_deserializer;
  localparam int SYNC = 2;
  localparam int TMO  = 1024;
  localparam int W    = 26;
  localparam int PH   = 4;

  typedef struct packed {
    logic        start;
    logic        cmd;
    logic [13:0] addr;
    logic [7:0]  data;
    logic        par;
    logic        stop;
  } fr_t;

  typedef struct {
    logic        cmd;
    logic [13:0] addr;
    logic [7:0]  data;
    bit          flip;
    bit          stop;
    int          kind;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic sdata = 1'b0;
  logic [W-1:0] frame;
  logic valid, perr, ferr, busy;

  deserializer #(
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .sclk_i(sclk),
    .sdata_i(sdata),
    .frame_o(frame),
    .valid_o(valid),
    .parity_err_o(perr),
    .frame_err_o(ferr),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int last_rise_cyc = 0;

  // Observed pulses: 1 valid, 2 parity error, 3 frame error, 4 several at once
  int           ev_kind[$];
  logic [W-1:0] ev_frame[$];
  int           ev_cyc[$];

  always @(posedge clk) begin : mon
    int k;
    #1;
    if (valid || perr || ferr) begin
      if (int'(valid) + int'(perr) + int'(ferr) > 1) k = 4;
      else if (valid) k = 1;
      else if (perr) k = 2;
      else k = 3;
      ev_kind.push_back(k);
      ev_frame.push_back(frame);
      ev_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit even_par(input fr_t f);
    return ($countones({f.cmd, f.addr, f.data}) % 2) == 1;
  endfunction

  function automatic logic [W-1:0] mk(input logic c, input logic [13:0] a,
                                      input logic [7:0] d, input bit flip,
                                      input bit stop);
    fr_t f;
    f.start = 1'b1;
    f.cmd   = c;
    f.addr  = a;
    f.data  = d;
    f.stop  = stop;
    f.par   = even_par(f) ^ flip;
    return f;
  endfunction

  function automatic int model_kind(input logic [W-1:0] w);
    fr_t f;
    f = w;
    if (!f.stop) return 3;
    if (f.par != even_par(f)) return 2;
    return 1;
  endfunction

  task automatic send_bits(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sclk  = 1'b0;
      sdata = w[W-1-i];
      repeat (PH) @(negedge clk);
      sclk = 1'b1;
      last_rise_cyc = cyc;
      repeat (PH - 1) @(negedge clk);
    end
    @(negedge clk);
    sclk  = 1'b0;
    sdata = 1'b0;
  endtask

  task automatic noise(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sclk  = 1'b0;
      sdata = 1'b0;
      repeat (PH) @(negedge clk);
      sclk = 1'b1;
      repeat (PH) @(negedge clk);
    end
    sclk = 1'b0;
  endtask

  task automatic expect_one(input string name, input int kind,
                            input logic [W-1:0] fexp, input int budget,
                            output int pcyc);
    int t = 0;
    pcyc = -1;
    while (ev_kind.size() == 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    repeat (8) @(negedge clk);
    chk({name, " pulses"}, ev_kind.size(), 1);
    if (ev_kind.size() > 0) begin
      chk({name, " kind"}, ev_kind[0], kind);
      chk({name, " frame"}, ev_frame[0], fexp);
      pcyc = ev_cyc[0];
    end
    ev_kind.delete();
    ev_frame.delete();
    ev_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[5];
    logic [W-1:0] w;
    logic [W-1:0] prev;
    int           pc;
    int           lat;

    tbl[0] = '{1'b1, 14'h1234, 8'hAB, 1'b0, 1'b1, 1};
    tbl[1] = '{1'b0, 14'h0100, 8'h00, 1'b0, 1'b1, 1};
    tbl[2] = '{1'b1, 14'h1234, 8'hAB, 1'b1, 1'b1, 2};
    tbl[3] = '{1'b1, 14'h3FFF, 8'hFF, 1'b0, 1'b0, 3};
    tbl[4] = '{1'b0, 14'h02A5, 8'h5A, 1'b0, 1'b1, 1};

    repeat (3) @(negedge clk);
    chk("reset frame", frame, 0);
    chk("reset valid", valid, 0);
    chk("reset perr", perr, 0);
    chk("reset ferr", ferr, 0);
    chk("reset busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    prev = '0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("vec%0d idle busy", i), busy, 0);
      w = mk(tbl[i].cmd, tbl[i].addr, tbl[i].data, tbl[i].flip,
             tbl[i].stop);
      send_bits(w, W);
      expect_one($sformatf("vec%0d", i), tbl[i].kind, w, 60, pc);
      if (i == 0) begin
        lat = pc - (last_rise_cyc + 1);
        chk("latency in range", (lat >= SYNC + 1 && lat <= SYNC + 3), 1);
      end
      prev = w;
    end

    // Stalled sclk mid-frame: abort without touching frame_o
    w = mk(1'b1, 14'h0ABC, 8'h3C, 1'b0, 1'b1);
    send_bits(w, 10);
    chk("timeout busy mid", busy, 1);
    expect_one("timeout", 3, prev, TMO + 5, pc);
    chk("timeout busy after", busy, 0);

    // Reset in the middle of a frame discards it
    w = mk(1'b0, 14'h1555, 8'hC3, 1'b0, 1'b1);
    send_bits(w, 12);
    rst_n = 1'b0;
    #1;
    chk("midrst frame", frame, 0);
    chk("midrst busy", busy, 0);
    chk("midrst pulses", {valid, perr, ferr}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ev_kind.delete();
    ev_frame.delete();
    ev_cyc.delete();
    repeat (4) @(negedge clk);
    w = mk(1'b1, 14'h2222, 8'h99, 1'b0, 1'b1);
    send_bits(w, W);
    expect_one("post-reset", 1, w, 60, pc);

    for (int i = 0; i < 20; i++) begin
      noise($urandom_range(0, 2));
      w = mk(1'($urandom), 14'($urandom), 8'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0);
      chk($sformatf("rnd%0d idle busy", i), busy, 0);
      send_bits(w, W);
      expect_one($sformatf("rnd%0d", i), model_kind(w), w, 60, pc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
